spi_slave_port: RTL and testbench

- SPI mode-0 slave endpoint. It is the receiving end of the SPI master on the AHB bus and serves as the generic slave front-end for Nexys4-side peripherals.
- Oversamples SCLK/SS/MOSI on the local block clock and deserialises MSB-first bytes to a ready/ack interface.
- Serialises a host-supplied reply byte onto MISO in the same frame (full duplex).
- Flags rx overrun, tx underrun and frame boundaries.

---
 rtl/spi_slave_port.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_port.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave endpoint: oversampled SCLK/SS/MOSI, MSB-first full-duplex
// word transfer to a ready/ack receive port and a single-entry transmit holding register.
module spi_slave_port #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_TX     = '0
) (
  input  logic                  block_clk_i,
  input  logic                  rst_low_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_ss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ack_i,
  output logic                  rx_overrun_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_load_i,
  output logic                  tx_ready_o,
  output logic                  tx_underrun_o,
  input  logic                  flag_clr_i,
  output logic                  frame_active_o,
  output logic                  frame_end_o
);

  localparam int             CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_hist, ss_hist;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic                  start_frame, end_frame, rx_edge, tx_edge;
  logic                  word_done, reload, reload_full, load_accept;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] hold;

  // Synchroniser chains start at 0, so a select held low through reset
  // release is not mistaken for a new frame start.
  always_ff @(posedge block_clk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value of
      // its neighbour, which is what makes this a shift chain.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_hist <= sclk_s;
      ss_hist   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign ss_rise   = ss_s & ~ss_hist;
  assign ss_fall   = ~ss_s & ss_hist;

  always_ff @(posedge block_clk_i or negedge rst_low_i) begin
    if (!rst_low_i) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    rx_edge     = 1'b0;
    tx_edge     = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next  = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_next = IDLE;
          end_frame  = 1'b1;
        end else begin
          rx_edge = sclk_rise;
          tx_edge = sclk_fall;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_word     = {rx_shift, mosi_s};
  assign word_done   = rx_edge && (bit_cnt == LAST_BIT);
  // Frame start and every word boundary on the falling edge fetch the next reply.
  assign reload      = start_frame || (tx_edge && (bit_cnt == '0));
  assign reload_full = reload && !tx_ready_o;
  assign load_accept = tx_load_i && (tx_ready_o || reload_full);

  always_ff @(posedge block_clk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (start_frame) begin
      bit_cnt <= '0;
    end else if (rx_edge) begin
      rx_shift <= rx_word[DATA_WIDTH-2:0];
      bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge block_clk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      if (word_done && (!rx_valid_o || rx_ack_i)) begin
        rx_data_o  <= rx_word;
        rx_valid_o <= 1'b1;
      end else if (rx_ack_i) begin
        rx_valid_o <= 1'b0;
      end
      if (word_done && rx_valid_o && !rx_ack_i) rx_overrun_o <= 1'b1;
      else if (flag_clr_i)                      rx_overrun_o <= 1'b0;
    end
  end

  // MISO is the shifter MSB; clearing the shifter on deselect parks MISO low.
  always_ff @(posedge block_clk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      tx_shift      <= '0;
      hold          <= '0;
      tx_ready_o    <= 1'b1;
      tx_underrun_o <= 1'b0;
    end else begin
      if (end_frame)    tx_shift <= '0;
      else if (reload)  tx_shift <= reload_full ? hold : IDLE_TX;
      else if (tx_edge) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};

      if (load_accept)      hold <= tx_data_i;
      if (load_accept)      tx_ready_o <= 1'b0;
      else if (reload_full) tx_ready_o <= 1'b1;

      if (reload && !reload_full) tx_underrun_o <= 1'b1;
      else if (flag_clr_i)        tx_underrun_o <= 1'b0;
    end
  end

  always_ff @(posedge block_clk_i or negedge rst_low_i) begin
    if (!rst_low_i) frame_end_o <= 1'b0;
    else            frame_end_o <= end_frame;
  end

  assign spi_miso_o     = tx_shift[DATA_WIDTH-1];
  assign spi_miso_oe_o  = (state == ACTIVE);
  assign frame_active_o = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a bit-banged SPI master plus a word-level model of
// the receive slot, transmit holding register and sticky flags.
module tb_spi_slave_port;

  localparam int          DW      = 8;
  localparam int          HALF    = 5;
  localparam logic [7:0]  IDLE_TX = 8'h00;

  logic          clk = 1'b0;
  logic          rst_low = 1'b0;
  logic          sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic          miso, miso_oe;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_ack = 1'b0, rx_overrun;
  logic [DW-1:0] tx_data = '0;
  logic          tx_load = 1'b0, tx_ready, tx_underrun, flag_clr = 1'b0;
  logic          frame_active, frame_end;

  spi_slave_port #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .IDLE_TX(IDLE_TX)) dut (
    .block_clk_i   (clk),
    .rst_low_i     (rst_low),
    .spi_sclk_i    (sclk),
    .spi_ss_i      (ss),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (miso_oe),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ack_i      (rx_ack),
    .rx_overrun_o  (rx_overrun),
    .tx_data_i     (tx_data),
    .tx_load_i     (tx_load),
    .tx_ready_o    (tx_ready),
    .tx_underrun_o (tx_underrun),
    .flag_clr_i    (flag_clr),
    .frame_active_o(frame_active),
    .frame_end_o   (frame_end)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int fe_mark;

  always @(posedge clk) if (frame_end === 1'b1) fe_cnt <= fe_cnt + 1;

  // Word-level reference state.
  logic [7:0] m_rx_data;
  logic       m_rx_valid, m_overrun, m_underrun, m_full;
  logic [7:0] m_hold;
  logic [7:0] exp_tx;

  function automatic void m_reset();
    m_rx_data = '0; m_rx_valid = 0; m_overrun = 0; m_underrun = 0;
    m_full = 0; m_hold = '0;
  endfunction

  function automatic logic [7:0] m_reload();
    if (m_full) begin
      m_full = 0;
      return m_hold;
    end
    m_underrun = 1;
    return IDLE_TX;
  endfunction

  function automatic void m_word(input logic [7:0] w);
    if (!m_rx_valid) begin
      m_rx_data  = w;
      m_rx_valid = 1;
    end else begin
      m_overrun = 1;
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".rx_valid"},    rx_valid,    m_rx_valid);
    check({tag, ".rx_data"},     rx_data,     m_rx_data);
    check({tag, ".overrun"},     rx_overrun,  m_overrun);
    check({tag, ".underrun"},    tx_underrun, m_underrun);
    check({tag, ".tx_ready"},    tx_ready,    !m_full);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".miso"},         miso,         1'b0);
    check({tag, ".oe"},           miso_oe,      1'b0);
    check({tag, ".rx_valid"},     rx_valid,     1'b0);
    check({tag, ".rx_data"},      rx_data,      8'h00);
    check({tag, ".overrun"},      rx_overrun,   1'b0);
    check({tag, ".underrun"},     tx_underrun,  1'b0);
    check({tag, ".tx_ready"},     tx_ready,     1'b1);
    check({tag, ".frame_active"}, frame_active, 1'b0);
    check({tag, ".frame_end"},    frame_end,    1'b0);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    cycles(HALF);
    r = miso;
    sclk = 1'b1;
    cycles(HALF);
    sclk = 1'b0;
  endtask

  task automatic select_slave();
    ss = 1'b0;
    exp_tx = m_reload();
    cycles(HALF);
  endtask

  task automatic deselect_slave(input string tag);
    fe_mark = fe_cnt;
    cycles(HALF);
    ss = 1'b1;
    cycles(6);
    check({tag, ".frame_end_pulses"}, fe_cnt - fe_mark, 1);
    check({tag, ".frame_active"},     frame_active,     1'b0);
    check({tag, ".oe"},               miso_oe,          1'b0);
    check({tag, ".miso_idle"},        miso,             1'b0);
  endtask

  // One full word; the slave reloads its shifter on the last falling edge.
  task automatic word_step(input logic [7:0] w, input string tag);
    logic [7:0] r;
    for (int i = DW - 1; i >= 0; i--) spi_bit(w[i], r[i]);
    cycles(HALF);
    check({tag, ".master_rx"}, r, exp_tx);
    m_word(w);
    exp_tx = m_reload();
    check_regs(tag);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    cycles(1);
    rx_ack = 1'b0;
    m_rx_valid = 0;
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    cycles(1);
    tx_load = 1'b0;
    if (!m_full) begin
      m_full = 1;
      m_hold = d;
    end
  endtask

  task automatic clear_flags();
    flag_clr = 1'b1;
    cycles(1);
    flag_clr = 1'b0;
    m_overrun = 0;
    m_underrun = 0;
  endtask

  initial begin
    logic       r;
    logic [7:0] w;
    int         n;

    m_reset();
    cycles(3);
    check_reset_outputs("reset");
    rst_low = 1'b1;
    cycles(4);

    // Two-word frame with one loaded reply, acknowledging each word.
    load(8'hA5);
    check("load_a5.tx_ready", tx_ready, 1'b0);
    select_slave();
    check("f1.frame_active", frame_active, 1'b1);
    check("f1.oe",           miso_oe,      1'b1);
    check("f1.tx_ready",     tx_ready,     1'b1);
    word_step(8'h13, "f1.w0");
    ack();
    check("f1.ack0.rx_valid", rx_valid, 1'b0);
    word_step(8'h08, "f1.w1");
    ack();
    deselect_slave("f1");

    // Three unacknowledged words: only the first is kept.
    clear_flags();
    select_slave();
    for (int i = 0; i < 3; i++) word_step(8'($urandom), $sformatf("ovr.w%0d", i));
    deselect_slave("ovr");
    clear_flags();
    check_regs("ovr.clr");
    ack();

    // Aborted frame after five SCLK edges, then a clean frame.
    select_slave();
    spi_bit(1'b1, r);
    spi_bit(1'b0, r);
    mosi = 1'b1;
    cycles(HALF);
    sclk = 1'b1;
    fe_mark = fe_cnt;
    cycles(HALF);
    ss = 1'b1;
    cycles(6);
    sclk = 1'b0;
    cycles(6);
    check("part.frame_end_pulses", fe_cnt - fe_mark, 1);
    check_regs("part");
    select_slave();
    word_step(8'h3C, "part.next");
    ack();
    deselect_slave("part.next");

    // Second load while full is ignored.
    load(8'h11);
    check("load_11.tx_ready", tx_ready, 1'b0);
    load(8'h22);
    check("load_22.tx_ready", tx_ready, 1'b0);
    select_slave();
    check("ld.frame_start.tx_ready", tx_ready, 1'b1);
    word_step(8'($urandom), "ld.w0");
    ack();
    deselect_slave("ld");

    // Randomised frames.
    for (int f = 0; f < 6; f++) begin
      clear_flags();
      if ($urandom_range(1, 0) == 1) load(8'($urandom));
      select_slave();
      n = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) begin
        word_step(8'($urandom), $sformatf("rnd%0d.w%0d", f, i));
        if ($urandom_range(3, 0) != 0) ack();
        if ($urandom_range(1, 0) == 1) load(8'($urandom));
      end
      deselect_slave($sformatf("rnd%0d", f));
      if (m_rx_valid) ack();
    end

    // Asynchronous reset in the middle of a word.
    select_slave();
    word_step(8'($urandom_range(255, 1)), "rst.w0");
    load(8'($urandom));
    for (int i = 0; i < 4; i++) spi_bit(1'($urandom), r);
    fe_mark = fe_cnt;
    rst_low = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    m_reset();
    ss = 1'b1;
    cycles(4);
    rst_low = 1'b1;
    cycles(6);
    check("rst.no_frame_end", fe_cnt - fe_mark, 0);
    check("rst.frame_active", frame_active, 1'b0);
    select_slave();
    word_step(8'h5A, "rst.after");
    ack();
    deselect_slave("rst.after");

    // SCLK activity while deselected must not disturb anything.
    fe_mark = fe_cnt;
    for (int i = 0; i < 8; i++) spi_bit(1'($urandom), r);
    cycles(6);
    check("idle_sclk.oe",           miso_oe,          1'b0);
    check("idle_sclk.frame_active", frame_active,     1'b0);
    check("idle_sclk.frame_end",    fe_cnt - fe_mark, 0);
    check("idle_sclk.miso",         miso,             1'b0);
    check_regs("idle_sclk");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
